// File: rtl/cmul_partial_seq.sv
// cmul_partial_seq
// Sequences the four partial products of a complex multiply through one
// shared combinational floating-point multiplier. A sample (x, w) is latched
// in IDLE. Four cycles M0..M3 then present one operand pair each to the
// multiplier and capture its same-cycle result. The four products are held
// in HOLD until the downstream stage accepts them. The block does no
// arithmetic of its own: products pass through bit-exact.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_valid / o_ready   input handshake (accepted only in IDLE)
//   i_x_re, i_x_im      complex data sample
//   i_w_re, i_w_im      complex twiddle factor
//   o_mul_a, o_mul_b    operands to the shared multiplier (zero when unused)
//   i_mul_res           same-cycle product from that multiplier
//   o_valid / i_ready   output handshake (asserted only in HOLD)
//   o_p_rr, o_p_ii      x_re*w_re, x_im*w_im
//   o_p_ri, o_p_ir      x_re*w_im, x_im*w_re
module cmul_partial_seq #(
    parameter int SIZE_DATA = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_x_re,
    input  logic [SIZE_DATA-1:0] i_x_im,
    input  logic [SIZE_DATA-1:0] i_w_re,
    input  logic [SIZE_DATA-1:0] i_w_im,
    output logic [SIZE_DATA-1:0] o_mul_a,
    output logic [SIZE_DATA-1:0] o_mul_b,
    input  logic [SIZE_DATA-1:0] i_mul_res,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_p_rr,
    output logic [SIZE_DATA-1:0] o_p_ii,
    output logic [SIZE_DATA-1:0] o_p_ri,
    output logic [SIZE_DATA-1:0] o_p_ir
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        HOLD = 3'd5
    } state_t;

    state_t state_r, state_nxt_s;
    logic   accept_s;
    logic   ready_r, valid_r;

    logic [SIZE_DATA-1:0] x_re_r, x_im_r, w_re_r, w_im_r;
    logic [SIZE_DATA-1:0] mul_a_r, mul_b_r, mul_a_nxt_s, mul_b_nxt_s;
    logic [SIZE_DATA-1:0] p_rr_r, p_ii_r, p_ri_r, p_ir_r;

    // Next-state logic and input-accept decode
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = M0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            M0:      state_nxt_s = M1;
            M1:      state_nxt_s = M2;
            M2:      state_nxt_s = M3;
            M3:      state_nxt_s = HOLD;
            HOLD: begin
                if (i_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand pair for the state being entered. The multiplier operands are
    // registered, so the pair for M0 comes straight from the inputs (the
    // latches are not yet loaded), later pairs come from the latches.
    always_comb begin
        mul_a_nxt_s = {SIZE_DATA{1'b0}};
        mul_b_nxt_s = {SIZE_DATA{1'b0}};
        case (state_r)
            IDLE: begin
                if (i_valid) begin
                    mul_a_nxt_s = i_x_re;
                    mul_b_nxt_s = i_w_re;
                end else begin
                    mul_a_nxt_s = {SIZE_DATA{1'b0}};
                    mul_b_nxt_s = {SIZE_DATA{1'b0}};
                end
            end
            M0: begin
                mul_a_nxt_s = x_im_r;
                mul_b_nxt_s = w_im_r;
            end
            M1: begin
                mul_a_nxt_s = x_re_r;
                mul_b_nxt_s = w_im_r;
            end
            M2: begin
                mul_a_nxt_s = x_im_r;
                mul_b_nxt_s = w_re_r;
            end
            default: begin
                mul_a_nxt_s = {SIZE_DATA{1'b0}};
                mul_b_nxt_s = {SIZE_DATA{1'b0}};
            end
        endcase
    end

    // State register with handshake flags decoded from the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
            valid_r <= (state_nxt_s == HOLD);
        end
    end

    // Sample latch, loaded only when a sample is accepted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_re_r <= {SIZE_DATA{1'b0}};
            x_im_r <= {SIZE_DATA{1'b0}};
            w_re_r <= {SIZE_DATA{1'b0}};
            w_im_r <= {SIZE_DATA{1'b0}};
        end else if (accept_s) begin
            x_re_r <= i_x_re;
            x_im_r <= i_x_im;
            w_re_r <= i_w_re;
            w_im_r <= i_w_im;
        end
    end

    // Registered multiplier operands
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mul_a_r <= {SIZE_DATA{1'b0}};
            mul_b_r <= {SIZE_DATA{1'b0}};
        end else begin
            mul_a_r <= mul_a_nxt_s;
            mul_b_r <= mul_b_nxt_s;
        end
    end

    // Product capture: each register loads only in its own M state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            p_rr_r <= {SIZE_DATA{1'b0}};
            p_ii_r <= {SIZE_DATA{1'b0}};
            p_ri_r <= {SIZE_DATA{1'b0}};
            p_ir_r <= {SIZE_DATA{1'b0}};
        end else begin
            case (state_r)
                M0:      p_rr_r <= i_mul_res;
                M1:      p_ii_r <= i_mul_res;
                M2:      p_ri_r <= i_mul_res;
                M3:      p_ir_r <= i_mul_res;
                default: p_rr_r <= p_rr_r;
            endcase
        end
    end

    assign o_ready = ready_r;
    assign o_valid = valid_r;
    assign o_mul_a = mul_a_r;
    assign o_mul_b = mul_b_r;
    assign o_p_rr  = p_rr_r;
    assign o_p_ii  = p_ii_r;
    assign o_p_ri  = p_ri_r;
    assign o_p_ir  = p_ir_r;

endmodule

// File: tb/tb_cmul_partial_seq.sv
// Self-checking bench for cmul_partial_seq. A behavioural single-precision
// multiplier sits between o_mul_a/o_mul_b and i_mul_res. Expected products
// are computed from the sample with that same multiply, and the expected
// operand order comes straight from the definition of the four products.
module tb_cmul_partial_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, ready_out, valid_out, ready_in;
    logic [31:0] x_re, x_im, w_re, w_im;
    logic [31:0] mul_a, mul_b, mul_res;
    logic [31:0] p_rr, p_ii, p_ri, p_ir;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural IEEE-754 single multiply, round-to-nearest-even,
    // subnormals flushed to zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] ma, mb;
        logic [47:0] p;
        logic [24:0] kept;
        logic        rnd, st;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        ma = a[22:0];  mb = b[22:0];
        if ((ea == 8'hFF && ma != 23'd0) || (eb == 8'hFF && mb != 23'd0)) return 32'h7FC00000;
        if ((ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00)) return 32'h7FC00000;
        if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'd0};
        if (ea == 8'h00 || eb == 8'h00) return {s, 31'd0};
        p = {24'd0, 1'b1, ma} * {24'd0, 1'b1, mb};
        e = int'(ea) + int'(eb) - 127;
        if (p[47]) begin
            kept = {1'b0, p[47:24]}; rnd = p[23]; st = |p[22:0]; e = e + 1;
        end else begin
            kept = {1'b0, p[46:23]}; rnd = p[22]; st = |p[21:0];
        end
        if (rnd && (st || kept[0])) kept = kept + 25'd1;
        if (kept[24]) begin
            kept = {2'b01, 23'd0}; e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], kept[22:0]};
    endfunction

    assign mul_res = fmul(mul_a, mul_b);

    cmul_partial_seq #(.SIZE_DATA(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .o_ready(ready_out),
        .i_x_re(x_re), .i_x_im(x_im), .i_w_re(w_re), .i_w_im(w_im),
        .o_mul_a(mul_a), .o_mul_b(mul_b), .i_mul_res(mul_res),
        .o_valid(valid_out), .i_ready(ready_in),
        .o_p_rr(p_rr), .o_p_ii(p_ii), .o_p_ri(p_ri), .o_p_ir(p_ir)
    );

    function automatic logic [31:0] rand_float();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom();
        e = 8'($urandom_range(100, 154));
        return {r[31], e, r[22:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        x_re = 32'd0; x_im = 32'd0; w_re = 32'd0; w_im = 32'd0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: ready=%b valid=%b want ready=1 valid=0", ready_out, valid_out);
        end
        n_tests++;
        if ({p_rr, p_ii, p_ri, p_ir, mul_a, mul_b} !== 192'd0) begin
            n_fail++;
            $display("FAIL reset_data: rr=%h ii=%h ri=%h ir=%h a=%h b=%h want all 0",
                     p_rr, p_ii, p_ri, p_ir, mul_a, mul_b);
        end
        rst = 1'b0;
    endtask

    // Sends one sample with i_ready high and checks operand sequencing,
    // handshake flags, products and return to IDLE.
    task automatic test_sample(input logic [31:0] xr, input logic [31:0] xi,
                               input logic [31:0] wr, input logic [31:0] wi,
                               input string tag);
        logic [31:0] exp_a[4], exp_b[4], exp_p[4], got_p[4];
        int guard;
        exp_a = '{xr, xi, xr, xi};
        exp_b = '{wr, wi, wi, wr};
        for (int k = 0; k < 4; k++) exp_p[k] = fmul(exp_a[k], exp_b[k]);
        guard = 0;
        while (!ready_out && guard < 10) begin
            @(negedge clk); guard++;
        end
        n_tests++;
        if (ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: ready=%b want 1", tag, ready_out);
        end
        x_re = xr; x_im = xi; w_re = wr; w_im = wi;
        valid_in = 1'b1; ready_in = 1'b1;
        @(negedge clk);
        // Garbage with i_valid high during M0..M3 must be ignored.
        for (int k = 0; k < 4; k++) begin
            x_re = $urandom(); x_im = $urandom(); w_re = $urandom(); w_im = $urandom();
            n_tests++;
            if (mul_a !== exp_a[k] || mul_b !== exp_b[k] || ready_out !== 1'b0 || valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_op%0d: a=%h b=%h rdy=%b vld=%b want a=%h b=%h rdy=0 vld=0",
                         tag, k, mul_a, mul_b, ready_out, valid_out, exp_a[k], exp_b[k]);
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
        got_p = '{p_rr, p_ii, p_ri, p_ir};
        n_tests++;
        if (valid_out !== 1'b1 || ready_out !== 1'b0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin
            n_fail++;
            $display("FAIL %s_hold: vld=%b rdy=%b a=%h b=%h want vld=1 rdy=0 a=0 b=0",
                     tag, valid_out, ready_out, mul_a, mul_b);
        end
        n_tests++;
        if (got_p != exp_p) begin
            n_fail++;
            $display("FAIL %s_prod: rr=%h ii=%h ri=%h ir=%h want %h %h %h %h", tag,
                     got_p[0], got_p[1], got_p[2], got_p[3], exp_p[0], exp_p[1], exp_p[2], exp_p[3]);
        end
        @(negedge clk);
        n_tests++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin
            n_fail++;
            $display("FAIL %s_back_idle: rdy=%b vld=%b a=%h b=%h want rdy=1 vld=0 a=0 b=0",
                     tag, ready_out, valid_out, mul_a, mul_b);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_p[4], got_p[4];
        int guard;
        exp_p = '{32'h3F800000, 32'hC0400000, 32'hC0000000, 32'h3FC00000};
        x_re = 32'h40000000; x_im = 32'h40400000; w_re = 32'h3F000000; w_im = 32'hBF800000;
        valid_in = 1'b1; ready_in = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        guard = 0;
        while (!valid_out && guard < 10) begin
            @(negedge clk); guard++;
        end
        n_tests++;
        if (guard != 4) begin
            n_fail++;
            $display("FAIL bp_latency: valid after %0d extra cycles want 4", guard);
        end
        for (int c = 0; c < 7; c++) begin
            got_p = '{p_rr, p_ii, p_ri, p_ir};
            n_tests++;
            if (got_p != exp_p || valid_out !== 1'b1 || ready_out !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: rr=%h ii=%h ri=%h ir=%h vld=%b rdy=%b want fixed products vld=1 rdy=0",
                         c, got_p[0], got_p[1], got_p[2], got_p[3], valid_out, ready_out);
            end
            @(negedge clk);
        end
        ready_in = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b vld=%b want rdy=1 vld=0", ready_out, valid_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] smp[2][4];
        logic [31:0] exp_p[2][4], got_p[4];
        int acc[2];
        int acc_cnt, out_cnt;
        smp[0] = '{rand_float(), rand_float(), rand_float(), rand_float()};
        smp[1] = '{rand_float(), rand_float(), rand_float(), rand_float()};
        for (int s = 0; s < 2; s++) begin
            exp_p[s][0] = fmul(smp[s][0], smp[s][2]);
            exp_p[s][1] = fmul(smp[s][1], smp[s][3]);
            exp_p[s][2] = fmul(smp[s][0], smp[s][3]);
            exp_p[s][3] = fmul(smp[s][1], smp[s][2]);
        end
        acc_cnt = 0; out_cnt = 0; acc = '{0, 0};
        ready_in = 1'b1; valid_in = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (acc_cnt < 2) begin
                x_re = smp[acc_cnt][0]; x_im = smp[acc_cnt][1];
                w_re = smp[acc_cnt][2]; w_im = smp[acc_cnt][3];
            end else begin
                valid_in = 1'b0;
            end
            if (valid_out) begin
                got_p = '{p_rr, p_ii, p_ri, p_ir};
                n_tests++;
                if (out_cnt > 1 || got_p != exp_p[out_cnt]) begin
                    n_fail++;
                    $display("FAIL b2b_out%0d: rr=%h ii=%h ri=%h ir=%h unexpected", out_cnt,
                             got_p[0], got_p[1], got_p[2], got_p[3]);
                end
                out_cnt++;
            end
            if (ready_out && valid_in && acc_cnt < 2) begin
                acc[acc_cnt] = cyc;
                acc_cnt++;
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
        n_tests++;
        if (acc_cnt != 2 || acc[1] - acc[0] != 6) begin
            n_fail++;
            $display("FAIL b2b_spacing: accepts=%0d gap=%0d want accepts=2 gap=6", acc_cnt, acc[1] - acc[0]);
        end
        n_tests++;
        if (out_cnt != 2) begin
            n_fail++;
            $display("FAIL b2b_outcount: got %0d outputs want 2", out_cnt);
        end
    endtask

    task automatic test_reset_midop();
        x_re = 32'h40000000; x_im = 32'h40400000; w_re = 32'h3F000000; w_im = 32'hBF800000;
        valid_in = 1'b1; ready_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        // Now in M2: rr and ii already captured.
        n_tests++;
        if (p_rr !== 32'h3F800000 || p_ii !== 32'hC0400000) begin
            n_fail++;
            $display("FAIL rstmid_pre: rr=%h ii=%h want 3f800000 c0400000", p_rr, p_ii);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0 ||
            {p_rr, p_ii, p_ri, p_ir, mul_a, mul_b} !== 192'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: rdy=%b vld=%b rr=%h ii=%h a=%h b=%h want rdy=1 vld=0 zeros",
                     ready_out, valid_out, p_rr, p_ii, mul_a, mul_b);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid_quiet%0d: vld=%b rdy=%b want vld=0 rdy=1", c, valid_out, ready_out);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v[4];
        logic [31:0] specials[6];
        logic [2:0]  pick;
        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h3F800000};
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 4; k++) begin
                pick = 3'($urandom_range(0, 7));
                v[k] = (pick < 3'd6) && (n % 3 == 2) ? specials[pick] : rand_float();
            end
            test_sample(v[0], v[1], v[2], v[3], "rand");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sample(32'h40000000, 32'h40400000, 32'h3F000000, 32'hBF800000, "basic");
        test_backpressure();
        test_back_to_back();
        test_sample(32'h00000000, 32'h7F800000, 32'h3F800000, 32'h3F800000, "special");
        test_reset_midop();
        test_sample(32'h40000000, 32'h40400000, 32'h3F000000, 32'hBF800000, "after_rst");
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
